// File: rtl/dm_sba_ctrl.sv
// System Bus Access engine: validates sbcs access settings, runs one req/gnt/r_valid
// transaction per trigger and returns lane-aligned read data or an sberror code.
module dm_sba_ctrl #(
  parameter int unsigned BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbautoincrement_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  input  logic [2:0]            sberror_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i
);

  localparam int unsigned BeW       = BusWidth / 8;
  localparam int unsigned OffW      = $clog2(BeW);
  localparam logic [2:0]  MaxAccess = 3'(OffW);

  typedef enum logic [2:0] {
    Idle      = 3'd0,
    Read      = 3'd1,
    Write     = 3'd2,
    WaitRead  = 3'd3,
    WaitWrite = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BusWidth-1:0] sbaddress_q, sbaddress_d;
  logic [BusWidth-1:0] sbdata_q, sbdata_d;
  logic [BusWidth-1:0] wdata_q, wdata_d;
  logic [2:0]          access_q, access_d;
  logic                autoinc_q, autoinc_d;
  logic                sbdata_valid_q, sbdata_valid_d;
  logic                sberror_valid_q, sberror_valid_d;
  logic [2:0]          sberror_q, sberror_d;

  logic [OffW-1:0]     off;
  logic [BeW-1:0]      size_mask;
  logic [BusWidth-1:0] rdata_shifted, rdata_masked;
  logic [BusWidth-1:0] addr_eff, align_mask, incr;
  logic                trig_write, trig_read, accept, in_req;
  int unsigned         nbytes;

  assign off    = sbaddress_q[OffW-1:0];
  assign nbytes = 32'd1 << access_q;
  assign incr   = BusWidth'(1) << access_q;

  // Byte lanes covered by the captured access size, before shifting to the address offset.
  always_comb begin
    size_mask = '0;
    for (int unsigned i = 0; i < BeW; i++) size_mask[i] = (i < nbytes);
  end

  assign rdata_shifted = master_r_rdata_i >> {off, 3'b000};

  always_comb begin
    rdata_masked = '0;
    for (int unsigned i = 0; i < BeW; i++)
      rdata_masked[8*i +: 8] = size_mask[i] ? rdata_shifted[8*i +: 8] : 8'h00;
  end

  // A same-cycle sbaddress write is the address the new access will use.
  assign addr_eff   = sbaddress_write_valid_i ? sbaddress_i : sbaddress_q;
  assign align_mask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);

  assign trig_write = sbdata_write_valid_i;
  assign trig_read  = (sbaddress_write_valid_i & sbreadonaddr_i) |
                      (sbdata_read_valid_i & sbreadondata_i);
  assign accept     = (sberror_i == 3'd0) & (trig_write | trig_read);

  always_comb begin
    state_d         = state_q;
    sbaddress_d     = sbaddress_q;
    sbdata_d        = sbdata_q;
    wdata_d         = wdata_q;
    access_d        = access_q;
    autoinc_d       = autoinc_q;
    sbdata_valid_d  = 1'b0;
    sberror_valid_d = 1'b0;
    sberror_d       = sberror_q;

    if (!dmactive_i) begin
      state_d = Idle;
      if (state_q == Idle && sbaddress_write_valid_i) sbaddress_d = sbaddress_i;
    end else begin
      unique case (state_q)
        Idle: begin
          if (sbaddress_write_valid_i) sbaddress_d = sbaddress_i;
          if (accept) begin
            if (sbaccess_i > MaxAccess) begin
              sberror_valid_d = 1'b1;
              sberror_d       = 3'd4;
            end else if ((addr_eff & align_mask) != '0) begin
              sberror_valid_d = 1'b1;
              sberror_d       = 3'd3;
            end else begin
              access_d  = sbaccess_i;
              autoinc_d = sbautoincrement_i;
              wdata_d   = sbdata_i;
              state_d   = trig_write ? Write : Read;
            end
          end
        end
        Read:  if (master_gnt_i) state_d = WaitRead;
        Write: if (master_gnt_i) state_d = WaitWrite;
        WaitRead, WaitWrite: begin
          if (master_r_valid_i) begin
            state_d = Idle;
            if (master_r_err_i) begin
              sberror_valid_d = 1'b1;
              sberror_d       = 3'd2;
            end else begin
              if (state_q == WaitRead) begin
                sbdata_d       = rdata_masked;
                sbdata_valid_d = 1'b1;
              end
              if (autoinc_q) sbaddress_d = sbaddress_q + incr;
            end
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= Idle;
      sbaddress_q     <= '0;
      sbdata_q        <= '0;
      wdata_q         <= '0;
      access_q        <= 3'd0;
      autoinc_q       <= 1'b0;
      sbdata_valid_q  <= 1'b0;
      sberror_valid_q <= 1'b0;
      sberror_q       <= 3'd0;
    end else begin
      state_q         <= state_d;
      sbaddress_q     <= sbaddress_d;
      sbdata_q        <= sbdata_d;
      wdata_q         <= wdata_d;
      access_q        <= access_d;
      autoinc_q       <= autoinc_d;
      sbdata_valid_q  <= sbdata_valid_d;
      sberror_valid_q <= sberror_valid_d;
      sberror_q       <= sberror_d;
    end
  end

  assign in_req          = (state_q == Read) || (state_q == Write);
  assign sbaddress_o     = sbaddress_q;
  assign sbdata_o        = sbdata_q;
  assign sbdata_valid_o  = sbdata_valid_q;
  assign sberror_valid_o = sberror_valid_q;
  assign sberror_o       = sberror_q;
  assign sbbusy_o        = (state_q != Idle);
  assign master_req_o    = in_req;
  assign master_we_o     = (state_q == Write);
  assign master_add_o    = sbaddress_q;
  assign master_wdata_o  = master_we_o ? (wdata_q << {off, 3'b000}) : '0;
  assign master_be_o     = in_req ? (size_mask << off) : '0;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Scoreboard bench for dm_sba_ctrl: expected data/error pulses are queued at trigger
// time and popped by a monitor; bus-side fields are checked inline by each scenario.
module tb_dm_sba_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmactive_i;
  logic [31:0] sbaddress_i;
  logic        sbaddress_write_valid_i;
  logic        sbreadonaddr_i;
  logic [2:0]  sbaccess_i;
  logic        sbautoincrement_i;
  logic        sbreadondata_i;
  logic [31:0] sbdata_i;
  logic        sbdata_write_valid_i;
  logic        sbdata_read_valid_i;
  logic [2:0]  sberror_i;
  logic [31:0] sbaddress_o;
  logic [31:0] sbdata_o;
  logic        sbdata_valid_o;
  logic        sbbusy_o;
  logic        sberror_valid_o;
  logic [2:0]  sberror_o;
  logic        master_req_o;
  logic [31:0] master_add_o;
  logic        master_we_o;
  logic [31:0] master_wdata_o;
  logic [3:0]  master_be_o;
  logic        master_gnt_i;
  logic        master_r_valid_i;
  logic        master_r_err_i;
  logic [31:0] master_r_rdata_i;

  typedef struct {
    bit          is_err;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dm_sba_ctrl #(.BusWidth(32)) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .dmactive_i             (dmactive_i),
    .sbaddress_i            (sbaddress_i),
    .sbaddress_write_valid_i(sbaddress_write_valid_i),
    .sbreadonaddr_i         (sbreadonaddr_i),
    .sbaccess_i             (sbaccess_i),
    .sbautoincrement_i      (sbautoincrement_i),
    .sbreadondata_i         (sbreadondata_i),
    .sbdata_i               (sbdata_i),
    .sbdata_write_valid_i   (sbdata_write_valid_i),
    .sbdata_read_valid_i    (sbdata_read_valid_i),
    .sberror_i              (sberror_i),
    .sbaddress_o            (sbaddress_o),
    .sbdata_o               (sbdata_o),
    .sbdata_valid_o         (sbdata_valid_o),
    .sbbusy_o               (sbbusy_o),
    .sberror_valid_o        (sberror_valid_o),
    .sberror_o              (sberror_o),
    .master_req_o           (master_req_o),
    .master_add_o           (master_add_o),
    .master_we_o            (master_we_o),
    .master_wdata_o         (master_wdata_o),
    .master_be_o            (master_be_o),
    .master_gnt_i           (master_gnt_i),
    .master_r_valid_i       (master_r_valid_i),
    .master_r_err_i         (master_r_err_i),
    .master_r_rdata_i       (master_r_rdata_i)
  );

  // Every data or error pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sbdata_valid_o === 1'b1) begin
        vectors++;
        if (sb_q.size() == 0 || sb_q[0].is_err) begin
          miscompares++;
          $display("FAIL data_pulse: unexpected sbdata_valid_o with sbdata_o=%h", sbdata_o);
        end else begin
          mon_e = sb_q.pop_front();
          if (sbdata_o !== mon_e.val) begin
            miscompares++;
            $display("FAIL rdata: sbdata_o=%h, required %h", sbdata_o, mon_e.val);
          end
        end
      end
      if (sberror_valid_o === 1'b1) begin
        vectors++;
        if (sb_q.size() == 0 || !sb_q[0].is_err) begin
          miscompares++;
          $display("FAIL err_pulse: unexpected sberror_valid_o with sberror_o=%0d", sberror_o);
        end else begin
          mon_e = sb_q.pop_front();
          if (sberror_o !== mon_e.val[2:0]) begin
            miscompares++;
            $display("FAIL errcode: sberror_o=%0d, required %0d", sberror_o, mon_e.val[2:0]);
          end
        end
      end
    end
  end

  task automatic push(input bit is_err, input logic [31:0] val);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    sb_q.push_back(e);
  endtask

  task automatic set_addr(input logic [31:0] addr, input logic roa);
    sbaddress_i             = addr;
    sbreadonaddr_i          = roa;
    sbaddress_write_valid_i = 1'b1;
    @(negedge clk);
    sbaddress_write_valid_i = 1'b0;
  endtask

  task automatic write_data(input logic [31:0] data);
    sbdata_i             = data;
    sbdata_write_valid_i = 1'b1;
    @(negedge clk);
    sbdata_write_valid_i = 1'b0;
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic no_req(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (master_req_o !== 1'b0 || sbbusy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s: req=%b busy=%b, required 0 0", nm, master_req_o, sbbusy_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input string nm);
    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0 || sbbusy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: pending=%0d busy=%b, required 0 0", nm, sb_q.size(), sbbusy_o);
      sb_q.delete();
    end
  endtask

  // Bus slave: checks held request fields, grants after gdly cycles, then responds.
  task automatic serve(input string nm, input int gdly, input logic [31:0] rdata, input logic err,
                       input logic exp_we, input logic [31:0] exp_add, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd);
    int n = 0;
    while (master_req_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i <= gdly; i++) begin
      vectors++;
      if (master_req_o !== 1'b1 || master_we_o !== exp_we || master_add_o !== exp_add ||
          master_be_o !== exp_be || (exp_we && master_wdata_o !== exp_wd)) begin
        miscompares++;
        $display("FAIL %s_req%0d: req=%b we=%b add=%h be=%b wd=%h, required 1 %b %h %b %h",
                 nm, i, master_req_o, master_we_o, master_add_o, master_be_o, master_wdata_o,
                 exp_we, exp_add, exp_be, exp_wd);
      end
      if (i == gdly) master_gnt_i = 1'b1;
      @(negedge clk);
    end
    master_gnt_i = 1'b0;
    vectors++;
    if (master_req_o !== 1'b0 || sbbusy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_wait: req=%b busy=%b, required 0 1", nm, master_req_o, sbbusy_o);
    end
    master_r_valid_i = 1'b1;
    master_r_err_i   = err;
    master_r_rdata_i = rdata;
    @(negedge clk);
    master_r_valid_i = 1'b0;
    master_r_err_i   = 1'b0;
    master_r_rdata_i = '0;
  endtask

  task automatic test_reset();
    vectors++;
    if (sbaddress_o !== 32'h0 || sbdata_o !== 32'h0 || sbdata_valid_o !== 1'b0 ||
        sbbusy_o !== 1'b0 || sberror_valid_o !== 1'b0 || master_req_o !== 1'b0 ||
        master_we_o !== 1'b0 || master_be_o !== 4'h0 || master_wdata_o !== 32'h0 ||
        master_add_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: addr=%h data=%h busy=%b req=%b be=%b, required all zero",
               sbaddress_o, sbdata_o, sbbusy_o, master_req_o, master_be_o);
    end
  endtask

  task automatic test_read_word();
    sbaccess_i = 3'd2;
    push(1'b0, 32'hDEADBEEF);
    set_addr(32'h1000, 1'b1);
    serve("read_word", 2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h1000, 4'hF, 32'h0);
    drain("read_word");
    check_val("read_word_data", sbdata_o, 32'hDEADBEEF);
    check_val("read_word_addr", sbaddress_o, 32'h1000);
  endtask

  task automatic test_write_byte();
    sbaccess_i        = 3'd0;
    sbautoincrement_i = 1'b1;
    set_addr(32'h1003, 1'b0);
    write_data(32'hA5);
    serve("write_byte", 1, 32'h0, 1'b0, 1'b1, 32'h1003, 4'b1000, 32'hA500_0000);
    drain("write_byte");
    check_val("write_byte_inc", sbaddress_o, 32'h1004);
    check_val("write_byte_data", sbdata_o, 32'hDEADBEEF);
    sbautoincrement_i = 1'b0;
  endtask

  task automatic test_precheck();
    sbaccess_i = 3'd2;
    push(1'b1, 32'd3);
    set_addr(32'h1002, 1'b1);
    no_req("misalign", 3);
    check_val("misalign_addr", sbaddress_o, 32'h1002);
    sbaccess_i = 3'd3;
    push(1'b1, 32'd4);
    set_addr(32'h1000, 1'b1);
    no_req("badsize", 3);
    drain("precheck");
    // halfword read at offset 2: data comes from the upper lanes, right-aligned
    sbaccess_i = 3'd1;
    push(1'b0, 32'h0000_1234);
    set_addr(32'h1002, 1'b1);
    serve("half_read", 0, 32'h1234_5678, 1'b0, 1'b0, 32'h1002, 4'b1100, 32'h0);
    drain("half_read");
    // sticky sberror blocks new triggers
    sberror_i  = 3'd3;
    sbaccess_i = 3'd2;
    write_data(32'h55);
    no_req("sticky_err", 3);
    sberror_i = 3'd0;
    drain("sticky_err");
  endtask

  task automatic test_bus_error();
    sbaccess_i        = 3'd2;
    sbautoincrement_i = 1'b1;
    push(1'b1, 32'd2);
    set_addr(32'h1000, 1'b1);
    serve("bus_err", 1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0);
    drain("bus_err");
    check_val("bus_err_data", sbdata_o, 32'h0000_1234);
    check_val("bus_err_addr", sbaddress_o, 32'h1000);
    sbautoincrement_i = 1'b0;
  endtask

  task automatic test_busy_and_dmactive();
    sbaccess_i = 3'd2;
    push(1'b0, 32'h0BADC0DE);
    set_addr(32'h1000, 1'b1);
    master_gnt_i = 1'b1;
    @(negedge clk);
    master_gnt_i            = 1'b0;
    sbaddress_i             = 32'h3000;
    sbaddress_write_valid_i = 1'b1;
    sbdata_write_valid_i    = 1'b1;
    sbreadondata_i          = 1'b1;
    sbdata_read_valid_i     = 1'b1;
    @(negedge clk);
    sbaddress_write_valid_i = 1'b0;
    sbdata_write_valid_i    = 1'b0;
    sbreadondata_i          = 1'b0;
    sbdata_read_valid_i     = 1'b0;
    check_val("busy_ignore_addr", sbaddress_o, 32'h1000);
    check_val("busy_ignore_state", {31'h0, sbbusy_o & ~master_req_o}, 32'h1);
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'h0BADC0DE;
    @(negedge clk);
    master_r_valid_i = 1'b0;
    drain("busy_ignore");
    check_val("busy_ignore_addr2", sbaddress_o, 32'h1000);
    // dmactive drop while waiting for the response
    set_addr(32'h1000, 1'b1);
    master_gnt_i = 1'b1;
    @(negedge clk);
    master_gnt_i = 1'b0;
    dmactive_i   = 1'b0;
    @(negedge clk);
    check_val("dmactive_idle", {30'h0, sbbusy_o, master_req_o}, 32'h0);
    dmactive_i       = 1'b1;
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    master_r_valid_i = 1'b0;
    drain("dmactive");
    check_val("dmactive_data", sbdata_o, 32'h0BADC0DE);
    check_val("dmactive_addr", sbaddress_o, 32'h1000);
  endtask

  task automatic test_back_to_back();
    sbaccess_i        = 3'd2;
    sbautoincrement_i = 1'b1;
    sbaddress_i             = 32'h2000;
    sbaddress_write_valid_i = 1'b1;
    sbreadonaddr_i          = 1'b1;
    sbdata_i                = 32'h1122_3344;
    sbdata_write_valid_i    = 1'b1;
    @(negedge clk);
    sbaddress_write_valid_i = 1'b0;
    sbdata_write_valid_i    = 1'b0;
    sbreadonaddr_i          = 1'b0;
    serve("prio_write", 1, 32'h0, 1'b0, 1'b1, 32'h2000, 4'hF, 32'h1122_3344);
    push(1'b0, 32'h5566_7788);
    sbreadondata_i      = 1'b1;
    sbdata_read_valid_i = 1'b1;
    @(negedge clk);
    sbdata_read_valid_i = 1'b0;
    sbreadondata_i      = 1'b0;
    serve("b2b_read", 0, 32'h5566_7788, 1'b0, 1'b0, 32'h2004, 4'hF, 32'h0);
    drain("b2b");
    check_val("b2b_addr", sbaddress_o, 32'h2008);
    sbautoincrement_i = 1'b0;
  endtask

  initial begin
    rst_n                   = 1'b0;
    dmactive_i              = 1'b1;
    sbaddress_i             = '0;
    sbaddress_write_valid_i = 1'b0;
    sbreadonaddr_i          = 1'b0;
    sbaccess_i              = 3'd2;
    sbautoincrement_i       = 1'b0;
    sbreadondata_i          = 1'b0;
    sbdata_i                = '0;
    sbdata_write_valid_i    = 1'b0;
    sbdata_read_valid_i     = 1'b0;
    sberror_i               = 3'd0;
    master_gnt_i            = 1'b0;
    master_r_valid_i        = 1'b0;
    master_r_err_i          = 1'b0;
    master_r_rdata_i        = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_read_word();
    test_write_byte();
    test_precheck();
    test_bus_error();
    test_busy_and_dmactive();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
